// File: rtl/sonar_pkg.sv
// Shared definitions for the sonar sweep control unit: state encoding
// (also exported on db_estado) and sweep mode constants.
package sonar_pkg;

    typedef enum logic [3:0] {
        INICIAL             = 4'h0,
        FAZ_ROTACAO         = 4'h1,
        AGUARDA_MEIO_TEMPO  = 4'h2,
        FAZ_MEDIDA          = 4'h3,
        AGUARDA_MEDIDA      = 4'h4,
        FAZ_TRANSMISSAO     = 4'h5,
        AGUARDA_TRANSMISSAO = 4'h6,
        AGUARDA_TEMPO       = 4'h7,
        PARADO              = 4'h8,
        FIM                 = 4'hF
    } estado_t;

    localparam logic MODO_CONTINUO = 1'b0;
    localparam logic MODO_UNICO    = 1'b1;

endpackage

// File: rtl/sonar_temporizador.sv
// Saturating up-counter with clear and enable; flags the half-way count and
// the final count of a T-cycle interval.
module sonar_temporizador
    import sonar_pkg::*;
#(
    parameter int T = 100
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic meio_o,
    output logic fim_tempo_o
);

    localparam int W = (T > 1) ? $clog2(T) : 1;
    localparam logic [W-1:0] CONT_MEIO = W'(T / 2 - 1);
    localparam logic [W-1:0] CONT_MAX  = W'(T - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Holding at CONT_MAX lets a late caller still see fim_tempo instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != CONT_MAX)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign meio_o      = (count_q == CONT_MEIO);
    assign fim_tempo_o = (count_q == CONT_MAX);

endmodule

// File: rtl/sonar_sweep_uc.sv
// Sonar sweep control unit: bounces the servo over N_POS positions, measuring
// and transmitting once per position, with measurement timeout and retries.
module sonar_sweep_uc
    import sonar_pkg::*;
#(
    parameter int N_POS     = 8,
    parameter int T_PERIOD  = 100_000_000,
    parameter int T_TIMEOUT = 2_500_000,
    parameter int N_RETRY   = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      ligar,
    input  logic                      modo,
    input  logic                      medida_pronto,
    input  logic                      envio_pronto,
    output logic                      medir,
    output logic                      transmitir,
    output logic                      girar,
    output logic                      pronto,
    output logic [$clog2(N_POS)-1:0]  posicao,
    output logic                      sentido,
    output logic                      erro_medida,
    output logic [3:0]                db_estado
);

    localparam int PW = $clog2(N_POS);
    localparam int TW = (N_RETRY > 0) ? $clog2(N_RETRY + 1) : 1;
    localparam logic [PW-1:0] POS_ANTES_TOPO = PW'(N_POS - 2);
    localparam logic [PW-1:0] POS_UM         = PW'(1);
    localparam logic [TW-1:0] RETRY_MAX      = TW'(N_RETRY);

    estado_t       estado_q, estado_d;
    logic [PW-1:0] posicao_q, posicao_d;
    logic          sentido_q, sentido_d;
    logic          erro_q, erro_d;
    logic [TW-1:0] tentativas_q, tentativas_d;

    logic periodoClear, periodoEnable, periodoMeio, periodoFim;
    logic timeoutClear, timeoutFim, unusedTimeoutMeio;

    assign periodoClear  = (estado_q == INICIAL) || (estado_q == FIM);
    assign periodoEnable = !((estado_q == INICIAL) || (estado_q == PARADO) || (estado_q == FIM));
    assign timeoutClear  = (estado_q != AGUARDA_MEDIDA);

    sonar_temporizador #(.T(T_PERIOD)) uPeriodo (
        .clock       (clock),
        .reset       (reset),
        .clear_i     (periodoClear),
        .enable_i    (periodoEnable),
        .meio_o      (periodoMeio),
        .fim_tempo_o (periodoFim)
    );

    sonar_temporizador #(.T(T_TIMEOUT)) uTimeout (
        .clock       (clock),
        .reset       (reset),
        .clear_i     (timeoutClear),
        .enable_i    (1'b1),
        .meio_o      (unusedTimeoutMeio),
        .fim_tempo_o (timeoutFim)
    );

    always_comb begin
        estado_d     = estado_q;
        posicao_d    = posicao_q;
        sentido_d    = sentido_q;
        erro_d       = erro_q;
        tentativas_d = tentativas_q;
        case (estado_q)
            INICIAL: begin
                tentativas_d = '0;
                if (ligar) estado_d = AGUARDA_MEIO_TEMPO;
            end
            AGUARDA_MEIO_TEMPO: if (periodoMeio) estado_d = FAZ_MEDIDA;
            FAZ_MEDIDA:         estado_d = AGUARDA_MEDIDA;
            AGUARDA_MEDIDA: begin
                if (medida_pronto) begin
                    estado_d = FAZ_TRANSMISSAO;
                end else if (timeoutFim) begin
                    if (tentativas_q < RETRY_MAX) begin
                        tentativas_d = tentativas_q + TW'(1);
                        estado_d     = FAZ_MEDIDA;
                    end else begin
                        erro_d   = 1'b1;
                        estado_d = FAZ_TRANSMISSAO;
                    end
                end
            end
            FAZ_TRANSMISSAO:     estado_d = AGUARDA_TRANSMISSAO;
            AGUARDA_TRANSMISSAO: if (envio_pronto) estado_d = AGUARDA_TEMPO;
            AGUARDA_TEMPO:       if (periodoFim) estado_d = FAZ_ROTACAO;
            // Bounce: the step into either end of the range also flips direction.
            FAZ_ROTACAO: begin
                estado_d = FIM;
                if (sentido_q) begin
                    posicao_d = posicao_q + PW'(1);
                    if (posicao_q == POS_ANTES_TOPO) sentido_d = 1'b0;
                end else begin
                    posicao_d = posicao_q - PW'(1);
                    if (posicao_q == POS_UM) sentido_d = 1'b1;
                end
            end
            FIM: begin
                if ((modo == MODO_UNICO) && (posicao_q == '0) && sentido_q) begin
                    estado_d = PARADO;
                end else begin
                    estado_d     = AGUARDA_MEIO_TEMPO;
                    tentativas_d = '0;
                    erro_d       = 1'b0;
                end
            end
            PARADO:  estado_d = PARADO;
            default: estado_d = INICIAL;
        endcase
        if (!ligar) begin
            estado_d = INICIAL;
            erro_d   = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q     <= INICIAL;
            posicao_q    <= '0;
            sentido_q    <= 1'b1;
            erro_q       <= 1'b0;
            tentativas_q <= '0;
        end else begin
            estado_q     <= estado_d;
            posicao_q    <= posicao_d;
            sentido_q    <= sentido_d;
            erro_q       <= erro_d;
            tentativas_q <= tentativas_d;
        end
    end

    assign medir       = (estado_q == FAZ_MEDIDA);
    assign transmitir  = (estado_q == FAZ_TRANSMISSAO);
    assign girar       = (estado_q == FAZ_ROTACAO);
    assign pronto      = (estado_q == FIM);
    assign posicao     = posicao_q;
    assign sentido     = sentido_q;
    assign erro_medida = erro_q;
    assign db_estado   = estado_q;

endmodule

// File: tb/tb_sonar_sweep_uc.sv
// Directed self-checking bench for sonar_sweep_uc with N_POS=4, T_PERIOD=20,
// T_TIMEOUT=6, N_RETRY=2; outputs are sampled on the falling clock edge.
module tb_sonar_sweep_uc;

   localparam int N_POS     = 4;
   localparam int T_PERIOD  = 20;
   localparam int T_TIMEOUT = 6;
   localparam int N_RETRY   = 2;

   localparam int MEDIR      = 0;
   localparam int TRANSMITIR = 1;
   localparam int GIRAR      = 2;
   localparam int MEDIDA     = 0;
   localparam int ENVIO      = 1;

   logic       clock = 1'b0;
   logic       reset, ligar, modo, medida_pronto, envio_pronto;
   logic       medir, transmitir, girar, pronto, sentido, erro_medida;
   logic [1:0] posicao;
   logic [3:0] db_estado;

   int compared   = 0;
   int mismatched = 0;
   int n;
   int extra;

   int   t1Pos[7]  = '{1, 2, 3, 2, 1, 0, 1};
   logic t1Sent[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
   int   t3Pos[6]  = '{1, 2, 3, 2, 1, 0};
   logic t3Sent[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
   int   t3Next[6] = '{2, 2, 2, 2, 2, 8};

   sonar_sweep_uc #(
      .N_POS     (N_POS),
      .T_PERIOD  (T_PERIOD),
      .T_TIMEOUT (T_TIMEOUT),
      .N_RETRY   (N_RETRY)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .ligar         (ligar),
      .modo          (modo),
      .medida_pronto (medida_pronto),
      .envio_pronto  (envio_pronto),
      .medir         (medir),
      .transmitir    (transmitir),
      .girar         (girar),
      .pronto        (pronto),
      .posicao       (posicao),
      .sentido       (sentido),
      .erro_medida   (erro_medida),
      .db_estado     (db_estado)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   function automatic logic strobe(input int which);
      case (which)
         MEDIR:      return medir;
         TRANSMITIR: return transmitir;
         default:    return girar;
      endcase
   endfunction

   // Cycles until the chosen strobe is seen; -1 when it never comes.
   task automatic waitStrobe(input int which, output int cycles);
      cycles = -1;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clock);
         if (strobe(which)) begin
            cycles = i;
            break;
         end
      end
   endtask

   // One-cycle done pulse, captured by the DUT 'delay' cycles after the current sample point.
   task automatic applyStimulus(input int which, input int delay);
      repeat (delay - 1) @(negedge clock);
      if (which == MEDIDA) medida_pronto = 1'b1;
      else                 envio_pronto  = 1'b1;
      @(negedge clock);
      medida_pronto = 1'b0;
      envio_pronto  = 1'b0;
   endtask

   // One full position, starting on the first cycle of aguarda_meio_tempo.
   task automatic doPosition(input int expPos, input logic expSent, input int expNext,
                             input int envioDelay, input int expGirar);
      int c;
      waitStrobe(MEDIR, c);
      checkOutput("medirDelay", 32'(c), 32'd10);
      applyStimulus(MEDIDA, 3);
      checkOutput("transmitir", 32'(transmitir), 32'd1);
      checkOutput("erroMedidaLimpo", 32'(erro_medida), 32'd0);
      applyStimulus(ENVIO, envioDelay);
      checkOutput("estadoAguardaTempo", 32'(db_estado), 32'd7);
      waitStrobe(GIRAR, c);
      checkOutput("girarDelay", 32'(c), 32'(expGirar));
      @(negedge clock);
      checkOutput("pronto", 32'(pronto), 32'd1);
      checkOutput("posicao", 32'(posicao), 32'(expPos));
      checkOutput("sentido", 32'(sentido), 32'(expSent));
      @(negedge clock);
      checkOutput("estadoAposFim", 32'(db_estado), 32'(expNext));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish within 20000 cycles");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b1; ligar = 1'b0; modo = 1'b0;
      medida_pronto = 1'b0; envio_pronto = 1'b0;
      repeat (3) @(negedge clock);
      checkOutput("resetEstado", 32'(db_estado), 32'd0);
      checkOutput("resetPosicao", 32'(posicao), 32'd0);
      checkOutput("resetSentido", 32'(sentido), 32'd1);
      checkOutput("resetErro", 32'(erro_medida), 32'd0);
      checkOutput("resetStrobes", 32'({medir, transmitir, girar, pronto}), 32'd0);

      $display("[TB] continuous sweep");
      reset = 1'b0; ligar = 1'b1;
      @(negedge clock);
      checkOutput("entradaMeioTempo", 32'(db_estado), 32'd2);
      for (int i = 0; i < 7; i++) doPosition(t1Pos[i], t1Sent[i], 2, 2, 5);

      $display("[TB] measurement never arrives");
      waitStrobe(MEDIR, n);
      checkOutput("medir1Delay", 32'(n), 32'd10);
      waitStrobe(MEDIR, n);
      checkOutput("medir2Spacing", 32'(n), 32'd7);
      waitStrobe(MEDIR, n);
      checkOutput("medir3Spacing", 32'(n), 32'd7);
      checkOutput("erroAntesEsgotar", 32'(erro_medida), 32'd0);
      waitStrobe(TRANSMITIR, n);
      checkOutput("transmitirAposEsgotar", 32'(n), 32'd7);
      checkOutput("erroComTransmitir", 32'(erro_medida), 32'd1);
      applyStimulus(ENVIO, 2);
      checkOutput("estadoAguardaTempoErro", 32'(db_estado), 32'd7);
      waitStrobe(GIRAR, n);
      checkOutput("girarSaturado", 32'(n), 32'd1);
      @(negedge clock);
      checkOutput("prontoErro", 32'(pronto), 32'd1);
      checkOutput("posicaoErro", 32'(posicao), 32'd2);
      checkOutput("erroNoFim", 32'(erro_medida), 32'd1);
      @(negedge clock);
      checkOutput("estadoAposErro", 32'(db_estado), 32'd2);
      checkOutput("erroLimpoAposFim", 32'(erro_medida), 32'd0);

      $display("[TB] late envio_pronto stretches the period");
      doPosition(3, 1'b0, 2, 30, 1);

      $display("[TB] ligar drop and reset mid-sweep");
      doPosition(2, 1'b0, 2, 2, 5);
      waitStrobe(MEDIR, n);
      checkOutput("medirAntesDesligar", 32'(n), 32'd10);
      @(negedge clock);
      checkOutput("estadoAguardaMedida", 32'(db_estado), 32'd4);
      ligar = 1'b0;
      @(negedge clock);
      checkOutput("desligadoEstado", 32'(db_estado), 32'd0);
      checkOutput("desligadoPosicao", 32'(posicao), 32'd2);
      checkOutput("desligadoSentido", 32'(sentido), 32'd0);
      ligar = 1'b1;
      @(negedge clock);
      checkOutput("religadoEstado", 32'(db_estado), 32'd2);
      waitStrobe(MEDIR, n);
      checkOutput("religadoMedir", 32'(n), 32'd10);
      reset = 1'b1;
      @(negedge clock);
      checkOutput("resetMeioEstado", 32'(db_estado), 32'd0);
      checkOutput("resetMeioPosicao", 32'(posicao), 32'd0);
      checkOutput("resetMeioSentido", 32'(sentido), 32'd1);
      checkOutput("resetMeioMedir", 32'(medir), 32'd0);

      $display("[TB] single sweep");
      reset = 1'b0; modo = 1'b1;
      @(negedge clock);
      checkOutput("unicoEntrada", 32'(db_estado), 32'd2);
      for (int i = 0; i < 6; i++) doPosition(t3Pos[i], t3Sent[i], t3Next[i], 2, 5);
      extra = 0;
      repeat (40) begin
         @(negedge clock);
         if (medir || girar) extra++;
      end
      checkOutput("paradoSemStrobes", 32'(extra), 32'd0);
      checkOutput("paradoEstado", 32'(db_estado), 32'd8);
      checkOutput("paradoPosicao", 32'(posicao), 32'd0);
      ligar = 1'b0;
      @(negedge clock);
      checkOutput("paradoDesligado", 32'(db_estado), 32'd0);

      $display("[TB] measurement and timeout in the same cycle");
      modo = 1'b0; ligar = 1'b1;
      @(negedge clock);
      checkOutput("simulEntrada", 32'(db_estado), 32'd2);
      waitStrobe(MEDIR, n);
      checkOutput("simulMedir", 32'(n), 32'd10);
      applyStimulus(MEDIDA, 7);
      checkOutput("simulEstado", 32'(db_estado), 32'd5);
      checkOutput("simulTransmitir", 32'(transmitir), 32'd1);
      checkOutput("simulErro", 32'(erro_medida), 32'd0);
      applyStimulus(ENVIO, 2);
      checkOutput("simulAguardaTempo", 32'(db_estado), 32'd7);
      waitStrobe(GIRAR, n);
      checkOutput("simulGirar", 32'(n), 32'd1);
      @(negedge clock);
      checkOutput("simulPronto", 32'(pronto), 32'd1);
      checkOutput("simulPosicao", 32'(posicao), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
